// File: rtl/conv3x3_ctrl.sv
// rtl/conv3x3_ctrl.sv - frame sequencer and 3x3 window builder for the mac9 datapath
// Optional feature macro CONV_RELU_EN: clamp negative results to zero.
module conv3x3_ctrl #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  output logic [9*COEF_W-1:0] kern_flat,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_W-1:0]    in_pix,
  output logic [9*PIX_W-1:0]  win_flat,
  output logic                win_valid,
  input  logic [ACC_W-1:0]    acc_in,
  output logic                out_valid,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [COEF_W-1:0] r_kern [9];
  logic [PIX_W-1:0]  r_lb0 [IMG_W];
  logic [PIX_W-1:0]  r_lb1 [IMG_W];
  logic [PIX_W-1:0]  r_win [9];
  logic              r_win_valid;
  logic              r_win_last;
  logic [1:0]        r_vpipe;
  logic [1:0]        r_lpipe;

  logic              w_accept;
  logic              w_col_wrap;
  logic              w_frame_end;
  logic              w_win_ok;
  logic              w_cfg_ok;
  logic [PIX_W-1:0]  w_lb0_rd;
  logic [PIX_W-1:0]  w_lb1_rd;
  logic [ACC_W-1:0]  w_result;

  assign in_ready    = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_col_wrap  = (r_col == COL_LAST);
  assign w_frame_end = w_accept && w_col_wrap && (r_row == ROW_LAST);
  assign w_win_ok    = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_cfg_ok    = cfg_we && (r_state == S_IDLE) && (cfg_addr < 4'd9);
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];

  // DRAIN exits once the last window has left the first two pipeline slots,
  // so DONE lands the cycle after out_last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_end) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_win_valid && !r_vpipe[0]) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 9; i++) r_kern[i] <= '0;
    end else if (w_cfg_ok) begin
      for (int i = 0; i < 9; i++) begin
        if (cfg_addr == 4'(i)) r_kern[i] <= cfg_data;
      end
    end
  end

  // Line buffer RAM carries no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_vpipe     <= '0;
      r_lpipe     <= '0;
    end else begin
      r_win_valid <= w_accept && w_win_ok;
      r_win_last  <= w_frame_end;
      r_vpipe     <= {r_vpipe[0], r_win_valid};
      r_lpipe     <= {r_lpipe[0], r_win_last};
    end
  end

  always_comb begin
    kern_flat = '0;
    win_flat  = '0;
    for (int i = 0; i < 9; i++) begin
      kern_flat[i*COEF_W +: COEF_W] = r_kern[i];
      win_flat[i*PIX_W +: PIX_W]    = r_win[i];
    end
  end

`ifdef CONV_RELU_EN
  assign w_result = acc_in[ACC_W-1] ? '0 : acc_in;
`else
  assign w_result = acc_in;
`endif

  assign win_valid = r_win_valid;
  assign out_valid = r_vpipe[1];
  assign out_last  = r_lpipe[1];
  assign out_data  = r_vpipe[1] ? w_result : '0;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// tb/tb_conv3x3_ctrl.sv - scoreboard bench for conv3x3_ctrl with a 2-stage MAC model
module tb_conv3x3_ctrl;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 32;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = (IMG_W - 2) * (IMG_H - 2);

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic                cfg_we = 1'b0;
  logic [3:0]          cfg_addr = '0;
  logic [COEF_W-1:0]   cfg_data = '0;
  logic [9*COEF_W-1:0] kern_flat;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [PIX_W-1:0]    in_pix = '0;
  logic [9*PIX_W-1:0]  win_flat;
  logic                win_valid;
  logic [ACC_W-1:0]    acc_in;
  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic                out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int tb_kern [9];
  int img [NPIX];
  logic [ACC_W-1:0] q_data [$];
  bit               q_last [$];
  int               q_cyc  [$];

  conv3x3_ctrl #(
    .PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .kern_flat(kern_flat),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .win_flat(win_flat), .win_valid(win_valid), .acc_in(acc_in),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mac9 stand-in: two register stages behind the window/kernel
  int               mac_sum;
  logic [ACC_W-1:0] mac_s1;
  logic [ACC_W-1:0] mac_s2;
  always_comb begin
    mac_sum = 0;
    for (int k = 0; k < 9; k++)
      mac_sum += int'($signed(kern_flat[k*COEF_W +: COEF_W])) * int'(win_flat[k*PIX_W +: PIX_W]);
  end
  always @(posedge clk) begin
    mac_s1 <= ACC_W'(mac_sum);
    mac_s2 <= mac_s1;
  end
  assign acc_in = mac_s2;

  function automatic logic [ACC_W-1:0] exp_at(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += tb_kern[i*3+j] * img[(r-2+i)*IMG_W + (c-2+j)];
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return ACC_W'(s);
  endfunction

  function automatic logic [9*COEF_W-1:0] kern_exp();
    logic [9*COEF_W-1:0] f;
    f = '0;
    for (int i = 0; i < 9; i++) f[i*COEF_W +: COEF_W] = COEF_W'(tb_kern[i]);
    return f;
  endfunction

  task automatic write_coef(input logic [3:0] a, input logic [COEF_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_kern();
    for (int i = 0; i < 9; i++) write_coef(4'(i), COEF_W'(tb_kern[i]));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    q_data.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic run_frame(input int gap_mode, input bit start_mid, output int n_out);
    int idx;
    int t;
    int last_acc;
    bit seen_done;
    logic [ACC_W-1:0] ed;
    bit el;
    int ec;
    idx = 0; t = 0; last_acc = -100; seen_done = 0; n_out = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %0b expected 1", busy); end
    while (!seen_done && t < 400) begin
      if (out_valid) begin
        n_out++;
        checks++;
        if (q_data.size() == 0) begin
          errors++; $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          ed = q_data.pop_front(); el = q_last.pop_front(); ec = q_cyc.pop_front();
          if (out_data !== ed) begin errors++; $display("FAIL out_data: got %0h expected %0h", out_data, ed); end
          checks++;
          if (out_last !== el) begin errors++; $display("FAIL out_last: got %0b expected %0b", out_last, el); end
          checks++;
          if (cyc !== ec + 3) begin errors++; $display("FAIL out_latency: got cycle %0d expected %0d", cyc, ec + 3); end
        end
      end
      if (done) begin
        seen_done = 1;
        checks++;
        if (cyc !== last_acc + 4) begin errors++; $display("FAIL done_cycle: got %0d expected %0d", cyc, last_acc + 4); end
        checks++;
        if (q_data.size() != 0) begin errors++; $display("FAIL missing_outputs: got %0d pending expected 0", q_data.size()); end
      end
      in_valid = 1'b0;
      if (!seen_done && idx < NPIX && (gap_mode == 0 || t % 2 == 0)) begin
        in_valid = 1'b1;
        in_pix = PIX_W'(img[idx]);
        if (in_ready) begin
          if (idx / IMG_W >= 2 && idx % IMG_W >= 2) begin
            q_data.push_back(exp_at(idx / IMG_W, idx % IMG_W));
            q_last.push_back(idx == NPIX - 1);
            q_cyc.push_back(cyc);
          end
          if (idx == NPIX - 1) last_acc = cyc;
          idx++;
        end
      end
      start = (start_mid && idx == 3) ? 1'b1 : 1'b0;
      t++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    if (!seen_done) begin errors++; checks++; $display("FAIL done_timeout: got no done expected done"); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_done_idle: got busy=%0b done=%0b expected 0 0", busy, done);
    end
    checks++;
    if (n_out !== NOUT) begin errors++; $display("FAIL out_count: got %0d expected %0d", n_out, NOUT); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, in_ready, out_valid, out_last, win_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %06b expected 000000", {busy, done, in_ready, out_valid, out_last, win_valid});
    end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++;
    if (kern_flat !== '0 || win_flat !== '0) begin
      errors++; $display("FAIL reset_kern_win: got %0h/%0h expected 0/0", kern_flat, win_flat);
    end
    rstn = 1'b1;
  endtask

  task automatic test_coef();
    for (int i = 0; i < 9; i++) tb_kern[i] = i + 1;
    load_kern();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (kern_flat[i*COEF_W +: COEF_W] !== COEF_W'(i + 1)) begin
        errors++; $display("FAIL coef_field%0d: got %0h expected %0h", i, kern_flat[i*COEF_W +: COEF_W], i + 1);
      end
    end
    write_coef(4'd12, 16'h7777);
    checks++;
    if (kern_flat !== kern_exp()) begin errors++; $display("FAIL coef_addr12: got %0h expected %0h", kern_flat, kern_exp()); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL coef_run_ready: got %0b expected 1", in_ready); end
    write_coef(4'd0, 16'd99);
    checks++;
    if (kern_flat !== kern_exp()) begin errors++; $display("FAIL coef_write_in_run: got %0h expected %0h", kern_flat, kern_exp()); end
    pulse_reset();
  endtask

  task automatic test_identity();
    int n;
    tb_kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < NPIX; i++) img[i] = i;
    load_kern();
    run_frame(0, 1'b0, n);
  endtask

  task automatic test_gaps();
    int n;
    tb_kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < NPIX; i++) img[i] = 1;
    load_kern();
    run_frame(1, 1'b0, n);
  endtask

  task automatic test_negative();
    int n;
    tb_kern = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < NPIX; i++) img[i] = 0;
    img[0] = 255;
    load_kern();
    run_frame(0, 1'b0, n);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 9; i++) tb_kern[i] = int'($urandom_range(200)) - 100;
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    load_kern();
    run_frame(0, 1'b1, n);
    run_frame(1, 1'b0, n);
  endtask

  task automatic test_abort();
    int n;
    bit bad_done;
    bit bad_valid;
    for (int i = 0; i < 9; i++) tb_kern[i] = int'($urandom_range(40)) - 20;
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    load_kern();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2*IMG_W + 4; i++) begin
      in_valid = 1'b1; in_pix = PIX_W'(img[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, win_valid, done} !== 5'b0) begin
      errors++; $display("FAIL abort_flags: got %05b expected 00000", {busy, in_ready, out_valid, win_valid, done});
    end
    checks++;
    if (out_data !== '0 || kern_flat !== '0) begin
      errors++; $display("FAIL abort_data_kern: got %0h/%0h expected 0/0", out_data, kern_flat);
    end
    @(negedge clk); rstn = 1'b1;
    bad_done = 0; bad_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) bad_done = 1;
      if (out_valid) bad_valid = 1;
    end
    checks++;
    if (bad_done || bad_valid) begin
      errors++; $display("FAIL abort_quiet: got done=%0b valid=%0b expected 0 0", bad_done, bad_valid);
    end
    q_data.delete(); q_last.delete(); q_cyc.delete();
    load_kern();
    run_frame(0, 1'b0, n);
  endtask

  initial begin
    test_reset();
    test_coef();
    test_identity();
    test_gaps();
    test_negative();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
